prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue capacity in bytes, power of two, >= 4.
REQ-002 SHALL have parameter POP_MAX, default 4: max bytes peeked/popped per cycle, 1..DEPTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port readyb, input, 1: active-low bus ready; data_in valid in a cycle where readyb=0 and a request is outstanding.
REQ-006 SHALL have port data_in, input, 16: bus read data, little-endian (byte at even address on [7:0]).
REQ-007 SHALL have port flush, input, 1: discard queue and restart fetch at flush_ps:flush_pc.
REQ-008 SHALL have ports flush_ps and flush_pc, input, 16 each: new segment and offset, sampled when flush=1.
REQ-009 SHALL have port pop_count, input, $clog2(POP_MAX+1): bytes consumed this cycle.
REQ-010 SHALL have port address_out, output, 20: physical fetch address.
REQ-011 SHALL have port bus_status, output, 4: 4'b1001 code fetch outstanding, 4'b1111 idle.
REQ-012 SHALL have port peek_data, output, 8*POP_MAX: oldest queued byte on [7:0], next on [15:8], etc.
REQ-013 SHALL have port valid_count, output, $clog2(DEPTH+1): bytes currently queued.
REQ-014 SHALL have port pfp, output, 16: current prefetch pointer offset.

Function
REQ-015 SHALL run a two-state fetch FSM: IDLE (bus_status=4'b1111) and REQ (bus_status=4'b1001).
REQ-016 SHALL drive address_out = ({PS,4'h0} + {4'h0,PFP}) mod 2^20, combinationally, in both states.
REQ-017 IDLE->REQ next cycle when no flush and free space (DEPTH - valid_count, before this cycle's pop) >= 2 for even PFP or >= 1 for odd PFP.
REQ-018 In REQ with readyb=1: hold REQ, address_out and bus_status unchanged (wait states unbounded).
REQ-019 In REQ with readyb=0, even PFP: push data_in[7:0] then data_in[15:8], PFP += 2, go to IDLE.
REQ-020 In REQ with readyb=0, odd PFP: push only data_in[15:8], PFP += 1, go to IDLE (realigns to word fetches).
REQ-021 PFP arithmetic SHALL wrap mod 2^16 within the segment; PS never changes except on flush/reset.
REQ-022 Pushed bytes SHALL be visible on peek_data/valid_count the cycle after the push edge.
REQ-023 Pop SHALL remove pop_count oldest bytes at the clock edge; push and pop in the same cycle SHALL yield valid_count_next = valid_count + pushed - popped.
REQ-024 pop_count > valid_count SHALL be ignored entirely (no pop that cycle), never underflow.
REQ-025 peek_data bytes at index >= valid_count SHALL read 8'h00.
REQ-026 Queue storage SHALL be a circular buffer with read/write pointers wrapping mod DEPTH.
REQ-027 flush=1 SHALL have priority over pop and push: next cycle valid_count=0, PS=flush_ps, PFP=flush_pc, FSM=IDLE, bus_status=4'b1111.
REQ-028 flush during REQ SHALL abandon the outstanding request; data_in in that cycle SHALL be discarded even if readyb=0.
REQ-029 After flush, a new request SHALL start no earlier than the second cycle after the flush cycle (IDLE for one cycle).
REQ-030 Full queue SHALL never overflow: no request is issued unless REQ-017 space condition holds.

Reset
REQ-031 reset=1 SHALL, at the clock edge, set PS=16'hFFFF, PFP=16'h0000, valid_count=0, FSM=IDLE, bus_status=4'b1111; address_out then reads 20'hFFFF0.
REQ-032 reset SHALL override flush, pop and any outstanding request (data in the reset cycle discarded).
REQ-033 First request after reset release SHALL assert bus_status=4'b1001 one cycle after reset deasserts.

Verification
REQ-034 Reset, readyb=0 always, data_in=16'hA1B2, no pops -> addresses FFFF0, FFFF2, FFFF4, FFFF6; queue B2,A1 repeated; requests stop at valid_count=8.
REQ-035 flush_ps=16'h1000, flush_pc=16'h0003 -> address 10003, push only data_in[15:8], then 10004, 10006 word fetches.
REQ-036 Queue full (8), pop_count=2 same cycle as readyb=0 with 1 free? -> no request issued at 8; after pop to 6, request issued, completes, valid_count=8.
REQ-037 flush asserted in REQ cycle with readyb=0 -> no bytes pushed, valid_count=0 next cycle, bus_status=4'b1111 for one cycle.
REQ-038 PFP=16'hFFFE, PS=16'h0000 -> fetch 0FFFE, next fetch address 00000 (segment wrap).
REQ-039 valid_count=3, pop_count=4 -> no pop, valid_count stays 3, peek_data[31:24]=8'h00.

Source files
------------

// File: rtl/prefetch_if.sv
// Bus and queue-side signal bundle for the instruction prefetch unit.
// master is the prefetch unit itself; slave is the bus/decoder environment.
interface prefetch_if #(
  parameter int DEPTH   = 8,
  parameter int POP_MAX = 4
);
  logic                         readyb;
  logic [15:0]                  data_in;
  logic                         flush;
  logic [15:0]                  flush_ps;
  logic [15:0]                  flush_pc;
  logic [$clog2(POP_MAX+1)-1:0] pop_count;
  logic [19:0]                  address_out;
  logic [3:0]                   bus_status;
  logic [8*POP_MAX-1:0]         peek_data;
  logic [$clog2(DEPTH+1)-1:0]   valid_count;
  logic [15:0]                  pfp;

  modport master (
    input  readyb, data_in, flush, flush_ps, flush_pc, pop_count,
    output address_out, bus_status, peek_data, valid_count, pfp
  );

  modport slave (
    output readyb, data_in, flush, flush_ps, flush_pc, pop_count,
    input  address_out, bus_status, peek_data, valid_count, pfp
  );
endinterface

// File: rtl/prefetch_unit.sv
// Segmented instruction prefetch queue: fetches 16-bit code words into a byte
// circular buffer and exposes up to POP_MAX oldest bytes for the decoder.
module prefetch_unit #(
  parameter int DEPTH   = 8,
  parameter int POP_MAX = 4
) (
  input  logic      clk,
  input  logic      reset,
  prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  logic [3:0]      status;
  logic [15:0]     ps;
  logic [15:0]     pfp;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [VW-1:0]   count;
  logic [7:0]      mem [DEPTH];

  logic [VW-1:0]   free;
  logic [VW-1:0]   need;
  logic [VW-1:0]   push_n;
  logic [VW-1:0]   pop_n;
  logic            bus_done;
  logic [8*POP_MAX-1:0] peek;

  // Space is judged before this cycle's pop so a request never needs a pop to fit.
  always_comb begin
    free     = VW'(DEPTH) - count;
    need     = pfp[0] ? VW'(1) : VW'(2);
    bus_done = (state == REQ) && !bus.readyb;
    push_n   = '0;
    if (bus_done) push_n = pfp[0] ? VW'(1) : VW'(2);
    pop_n    = (VW'(bus.pop_count) <= count) ? VW'(bus.pop_count) : '0;
  end

  always_comb begin
    peek = '0;
    for (int i = 0; i < POP_MAX; i++)
      if (VW'(i) < count) peek[8*i +: 8] = mem[rd_ptr + AW'(i)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      status <= 4'b1111;
      ps     <= 16'hFFFF;
      pfp    <= 16'h0000;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      status <= 4'b1111;
      ps     <= bus.flush_ps;
      pfp    <= bus.flush_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + push_n - pop_n;
      case (state)
        IDLE: begin
          if (free >= need) begin
            state  <= REQ;
            status <= 4'b1001;
          end
        end
        REQ: begin
          if (bus_done) begin
            // An odd pointer takes only the high byte, realigning to word fetches.
            if (pfp[0]) begin
              mem[wr_ptr] <= bus.data_in[15:8];
              wr_ptr      <= wr_ptr + AW'(1);
              pfp         <= pfp + 16'd1;
            end else begin
              mem[wr_ptr]          <= bus.data_in[7:0];
              mem[wr_ptr + AW'(1)] <= bus.data_in[15:8];
              wr_ptr               <= wr_ptr + AW'(2);
              pfp                  <= pfp + 16'd2;
            end
            state  <= IDLE;
            status <= 4'b1111;
          end
        end
        default: begin
          state  <= IDLE;
          status <= 4'b1111;
        end
      endcase
    end
  end

  assign bus.address_out = {ps, 4'h0} + {4'h0, pfp};
  assign bus.bus_status  = status;
  assign bus.peek_data   = peek;
  assign bus.valid_count = count;
  assign bus.pfp         = pfp;
endmodule
